// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// default NOP word and a helper that identifies the byte-accepting states.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      StLenLo = 3'd0,
      StLenHi = 3'd1,
      StData  = 3'd2,
      StCsum  = 3'd3,
      StRun   = 3'd4,
      StError = 3'd5
   } state_e;

   // addi x0,x0,0
   localparam logic [31:0] NopInstrDefault = 32'h00000013;

   // States in which the loader takes bytes from the stream
   function automatic logic is_loading(input state_e s);
      return (s == StLenLo) || (s == StLenHi) || (s == StData) || (s == StCsum);
   endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// Instruction RAM: 2**ADDR_W words of 32 bits, one synchronous write port,
// one combinational read port. Contents are never cleared by reset.
module imem_loader_ram #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem [2**ADDR_W];

   // Single write port, one word per completed image word
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader in front of the CPU. After reset it fills the RAM
// from a byte stream (len lo, len hi, N little-endian words) while holding the
// CPU in reset, then releases the CPU and serves fetches read-only.
// Optional feature: define CHECKSUM_EN to require a trailing XOR byte over all
// data bytes; a mismatch parks the loader in an error state with err=1.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [31:0] NOP_INSTR = NopInstrDefault
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic [31:0] PC,
   output logic [31:0] Instr,
   output logic        cpu_reset,
   output logic        load_done,
   output logic        overflow,
   output logic        err
);

`ifdef CHECKSUM_EN
   localparam state_e LoadEnd = StCsum;
`else
   localparam state_e LoadEnd = StRun;
`endif

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] asm_q, asm_d;
   logic        ovf_q, ovf_d;
   logic        rdy_q, rdy_d;
`ifdef CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   logic              accept;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic              last_word;
   logic              in_range;
   logic              unused_pc;

   assign accept    = rx_valid && rdy_q;
   // Little-endian: the current byte is the most significant of the word
   assign ram_wdata = {rx_data, asm_q};
   assign last_word = (word_cnt_q == (len_q - 16'd1));
   // Words past the RAM depth are consumed but never written (no wrap)
   assign in_range  = ((word_cnt_q >> ADDR_W) == 16'd0);
   assign unused_pc = ^{PC[31:ADDR_W+2], PC[1:0]};

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StLenLo;
         len_q      <= '0;
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         ovf_q      <= 1'b0;
         rdy_q      <= 1'b0;
`ifdef CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         ovf_q      <= ovf_d;
         rdy_q      <= rdy_d;
`ifdef CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   // Next-state logic: stream parsing, word assembly and RAM write strobe
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      ovf_d      = ovf_q;
      ram_we     = 1'b0;
`ifdef CHECKSUM_EN
      csum_d     = csum_q;
`endif
      unique case (state_q)
         StLenLo: begin
            if (accept) begin
               len_d[7:0] = rx_data;
               state_d    = StLenHi;
            end
         end
         StLenHi: begin
            if (accept) begin
               len_d[15:8] = rx_data;
               state_d     = ({rx_data, len_q[7:0]} != 16'd0) ? StData : LoadEnd;
            end
         end
         StData: begin
            if (accept) begin
               asm_d      = ram_wdata[31:8];
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef CHECKSUM_EN
               csum_d     = csum_q ^ rx_data;
`endif
               if (byte_cnt_q == 2'd3) begin
                  if (in_range) begin
                     ram_we = 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  word_cnt_d = word_cnt_q + 16'd1;
                  if (last_word) begin
                     state_d = LoadEnd;
                  end
               end
            end
         end
`ifdef CHECKSUM_EN
         StCsum: begin
            if (accept) begin
               state_d = (rx_data == csum_q) ? StRun : StError;
            end
         end
`endif
         default: ;
      endcase
      // Registered so rx_ready stays low until the first clock after reset
      rdy_d = is_loading(state_d);
   end

   imem_loader_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (word_cnt_q[ADDR_W-1:0]),
      .wdata_i (ram_wdata),
      .raddr_i (PC[ADDR_W+1:2]),
      .rdata_o (ram_rdata)
   );

   assign rx_ready  = rdy_q;
   assign load_done = (state_q == StRun);
   assign cpu_reset = (state_q != StRun);
   assign overflow  = ovf_q;
   assign Instr     = (state_q == StRun) ? ram_rdata : NOP_INSTR;
`ifdef CHECKSUM_EN
   assign err       = (state_q == StError);
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Two instances share one byte stream: the
// default depth and a 4-word depth used for the overflow case.
module tb_imem_loader;

   localparam logic [31:0] Nop = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [31:0] PC;

   logic        rx_ready, cpu_reset, load_done, overflow, err;
   logic [31:0] Instr;
   logic        rx_ready_s, cpu_reset_s, load_done_s, overflow_s, err_s;
   logic [31:0] Instr_s;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] img [8];
   logic [7:0]  xsum;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .PC        (PC),
      .Instr     (Instr),
      .cpu_reset (cpu_reset),
      .load_done (load_done),
      .overflow  (overflow),
      .err       (err)
   );

   imem_loader #(.ADDR_W(2)) dut_s (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready_s),
      .PC        (PC),
      .Instr     (Instr_s),
      .cpu_reset (cpu_reset_s),
      .load_done (load_done_s),
      .overflow  (overflow_s),
      .err       (err_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one byte, optionally after random idle cycles with data held
   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int gaps;
      int waited;
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gaps) begin
         @(negedge clk);
         rx_data  = b;
         rx_valid = 1'b0;
      end
      waited = 0;
      forever begin
         @(negedge clk);
         rx_data  = b;
         rx_valid = 1'b1;
         if (rx_ready) break;
         waited++;
         if (waited > 20) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic load_image(input int n, input int gap_max, input logic corrupt);
      xsum = 8'h00;
      send_byte(8'(n), gap_max);
      send_byte(8'(n >> 8), gap_max);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            xsum ^= img[i][8*k +: 8];
            send_byte(img[i][8*k +: 8], gap_max);
         end
      end
`ifdef CHECKSUM_EN
      send_byte(corrupt ? 8'h00 : xsum, gap_max);
`else
      if (corrupt) send_byte(8'h00, gap_max);
`endif
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      reset    = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic rd(input logic [31:0] pc, input logic [31:0] exp, input string tag);
      PC = pc;
      #1 check(tag, Instr, exp);
   endtask

   task automatic rd_s(input logic [31:0] pc, input logic [31:0] exp, input string tag);
      PC = pc;
      #1 check(tag, Instr_s, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      PC       = 32'h0;

      // Reset values
      @(negedge clk);
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_rx_ready",  32'(rx_ready),  32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      check("rst_err",       32'(err),       32'd0);
      check("rst_instr",     Instr,          Nop);
      #2 reset = 1'b1;
      #1 check("rdy_before_clk", 32'(rx_ready), 32'd0);
      @(negedge clk);
      check("rdy_after_clk", 32'(rx_ready), 32'd1);

      // Test 1: two-word image
      img[0] = 32'h00100513;
      img[1] = 32'h00200593;
      load_image(2, 0, 1'b0);
      check("t1_load_done", 32'(load_done), 32'd1);
      check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
      check("t1_rx_ready",  32'(rx_ready),  32'd0);
      check("t1_err",       32'(err),       32'd0);
      check("t1_overflow",  32'(overflow),  32'd0);
      rd(32'd0,    32'h00100513, "t1_pc0");
      rd(32'd4,    32'h00200593, "t1_pc4");
      rd(32'd6,    32'h00200593, "t1_pc6_lowbits");
      rd(32'd1028, 32'h00200593, "t1_pc1028_alias");

      // Bytes offered in RUN are ignored
      repeat (8) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = 8'hFF;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      rd(32'd0, 32'h00100513, "run_ignore_pc0");
      check("run_ignore_done", 32'(load_done), 32'd1);

      // Test 2: empty image, RAM untouched
      do_reset();
      load_image(0, 0, 1'b0);
      check("t2_load_done", 32'(load_done), 32'd1);
      check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
      rd(32'd0, 32'h00100513, "t2_pc0_kept");

      // Test 3: five words into a four-word RAM
      do_reset();
      img[0] = 32'hA0000001;
      img[1] = 32'hA0000002;
      img[2] = 32'hA0000003;
      img[3] = 32'hA0000004;
      img[4] = 32'hA0000005;
      load_image(5, 0, 1'b0);
      check("t3_overflow_s",  32'(overflow_s),  32'd1);
      check("t3_load_done_s", 32'(load_done_s), 32'd1);
      check("t3_overflow",    32'(overflow),    32'd0);
      rd_s(32'd0,  32'hA0000001, "t3_s_pc0");
      rd_s(32'd12, 32'hA0000004, "t3_s_pc12");
      rd_s(32'd16, 32'hA0000001, "t3_s_pc16_nowrap");
      rd(32'd16,   32'hA0000005, "t3_pc16");

      // Test 4: load another image, then the first image with random gaps
      do_reset();
      img[0] = 32'hAABBCCDD;
      img[1] = 32'h11223344;
      load_image(2, 0, 1'b0);
      rd(32'd0, 32'hAABBCCDD, "t4_aux_pc0");
      rd(32'd4, 32'h11223344, "t4_aux_pc4");
      do_reset();
      img[0] = 32'h00100513;
      img[1] = 32'h00200593;
      load_image(2, 3, 1'b0);
      check("t4_load_done", 32'(load_done), 32'd1);
      rd(32'd0, 32'h00100513, "t4_pc0");
      rd(32'd4, 32'h00200593, "t4_pc4");

      // Test 5: reset after five bytes, then a full re-stream
      do_reset();
      img[0] = 32'hAABBCCDD;
      img[1] = 32'h11223344;
      load_image(2, 0, 1'b0);
      do_reset();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      send_byte(8'h10, 0);
      @(negedge clk);
      check("t5_mid_cpu_reset", 32'(cpu_reset), 32'd1);
      check("t5_mid_load_done", 32'(load_done), 32'd0);
      check("t5_mid_rx_ready",  32'(rx_ready),  32'd1);
      rd(32'd0, Nop, "t5_mid_instr_nop");
      reset = 1'b0;
      #1;
      check("t5_rst_rx_ready",  32'(rx_ready),  32'd0);
      check("t5_rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("t5_rst_load_done", 32'(load_done), 32'd0);
      check("t5_rst_overflow",  32'(overflow),  32'd0);
      check("t5_rst_instr",     Instr,          Nop);
      #2 reset = 1'b1;
      img[0] = 32'h00100513;
      img[1] = 32'h00200593;
      load_image(2, 0, 1'b0);
      check("t5_load_done", 32'(load_done), 32'd1);
      rd(32'd0, 32'h00100513, "t5_pc0");
      rd(32'd4, 32'h00200593, "t5_pc4");

`ifdef CHECKSUM_EN
      // Test 6: checksum good and bad
      do_reset();
      load_image(2, 0, 1'b0);
      check("t6_good_done", 32'(load_done), 32'd1);
      check("t6_good_err",  32'(err),       32'd0);
      do_reset();
      load_image(2, 0, 1'b1);
      check("t6_bad_err",       32'(err),       32'd1);
      check("t6_bad_cpu_reset", 32'(cpu_reset), 32'd1);
      check("t6_bad_rx_ready",  32'(rx_ready),  32'd0);
      check("t6_bad_load_done", 32'(load_done), 32'd0);
      rd(32'd0, Nop, "t6_bad_instr_nop");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
